// File: rtl/bram_stride_agu.sv
// Multi-channel strided BRAM address generator.
// NUM_CH independent LENGTH/STRIDE/BASE sequencers share one request port
// through a round-robin arbiter; one word address per cycle under Nack.
// Optional feature macro: BRAM_AGU_ABORT_EN (Sel=4 aborts a running channel).
module bram_stride_agu #(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned WIDTH_ADDR = 13,
   parameter int unsigned WIDTH_LEN  = 13,
   parameter int unsigned WIDTH_CH   = $clog2(NUM_CH)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  I_Cfg_Valid,
   input  logic [WIDTH_CH-1:0]   I_Cfg_Ch,
   input  logic [2:0]            I_Cfg_Sel,
   input  logic [WIDTH_ADDR-1:0] I_Cfg_Data,
   output logic                  O_Cfg_Err,
   output logic                  O_Req_Valid,
   output logic [WIDTH_CH-1:0]   O_Req_Ch,
   output logic [WIDTH_ADDR-1:0] O_Req_Addr,
   input  logic                  I_Req_Nack,
   output logic [NUM_CH-1:0]     O_Busy,
   output logic [NUM_CH-1:0]     O_Done,
   output logic [NUM_CH-1:0]     O_Abort
);

   typedef enum logic {StIdle = 1'b0, StRun = 1'b1} ch_state_e;

   ch_state_e             state_q  [NUM_CH];
   ch_state_e             state_d  [NUM_CH];
   logic [WIDTH_LEN-1:0]  len_q    [NUM_CH];
   logic [WIDTH_LEN-1:0]  len_d    [NUM_CH];
   logic [WIDTH_LEN-1:0]  cnt_q    [NUM_CH];
   logic [WIDTH_LEN-1:0]  cnt_d    [NUM_CH];
   logic [WIDTH_ADDR-1:0] stride_q [NUM_CH];
   logic [WIDTH_ADDR-1:0] stride_d [NUM_CH];
   logic [WIDTH_ADDR-1:0] base_q   [NUM_CH];
   logic [WIDTH_ADDR-1:0] base_d   [NUM_CH];
   logic [WIDTH_ADDR-1:0] addr_q   [NUM_CH];
   logic [WIDTH_ADDR-1:0] addr_d   [NUM_CH];
   logic [WIDTH_CH-1:0]   rr_q, rr_d;
   logic                  cfg_err_q, cfg_err_d;
   logic [NUM_CH-1:0]     done_q, done_d;
`ifdef BRAM_AGU_ABORT_EN
   logic [NUM_CH-1:0]     abort_q, abort_d;
`endif

   logic                  req_valid;
   logic [WIDTH_CH-1:0]   grant;
   logic                  accept;
   logic [WIDTH_CH-1:0]   cfg_ch;

   assign cfg_ch = I_Cfg_Ch;
   assign accept = req_valid & ~I_Req_Nack;

   // Round-robin grant: first RUN channel at or after the pointer, cyclically.
   always_comb begin
      int unsigned idx;
      idx       = 0;
      grant     = '0;
      req_valid = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         idx = (32'(rr_q) + i) % NUM_CH;
         if (!req_valid && state_q[WIDTH_CH'(idx)] == StRun) begin
            grant     = WIDTH_CH'(idx);
            req_valid = 1'b1;
         end
      end
   end

   // Next-state: request accept first, then config; they touch different
   // channels except for the abort/last-word overlap handled explicitly.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      stride_d  = stride_q;
      base_d    = base_q;
      addr_d    = addr_q;
      rr_d      = rr_q;
      cfg_err_d = 1'b0;
      done_d    = '0;
`ifdef BRAM_AGU_ABORT_EN
      abort_d   = '0;
`endif

      if (accept) begin
         addr_d[grant] = addr_q[grant] + stride_q[grant];
         cnt_d[grant]  = cnt_q[grant] - 1'b1;
         rr_d          = (32'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;
         if (cnt_q[grant] == WIDTH_LEN'(1)) begin
            state_d[grant] = StIdle;
            done_d[grant]  = 1'b1;
         end
      end

      if (I_Cfg_Valid) begin
         if (32'(cfg_ch) >= NUM_CH) begin
            cfg_err_d = 1'b1;
         end else begin
            case (I_Cfg_Sel)
               3'd0, 3'd1, 3'd2, 3'd3: begin
                  if (state_q[cfg_ch] == StRun) begin
                     // Registers are frozen while the channel runs.
                     cfg_err_d = 1'b1;
                  end else begin
                     case (I_Cfg_Sel)
                        3'd0:    len_d[cfg_ch]    = I_Cfg_Data[WIDTH_LEN-1:0];
                        3'd1:    stride_d[cfg_ch] = I_Cfg_Data;
                        3'd2:    base_d[cfg_ch]   = I_Cfg_Data;
                        default: begin
                           if (len_q[cfg_ch] != '0) begin
                              addr_d[cfg_ch]  = base_q[cfg_ch];
                              cnt_d[cfg_ch]   = len_q[cfg_ch];
                              state_d[cfg_ch] = StRun;
                           end else begin
                              done_d[cfg_ch] = 1'b1;
                           end
                        end
                     endcase
                  end
               end
               3'd4: begin
`ifdef BRAM_AGU_ABORT_EN
                  if (state_q[cfg_ch] == StRun) begin
                     // A last-word accept in the same cycle completes normally.
                     if (!(accept && grant == cfg_ch && cnt_q[cfg_ch] == WIDTH_LEN'(1))) begin
                        state_d[cfg_ch] = StIdle;
                        abort_d[cfg_ch] = 1'b1;
                     end
                  end
`else
                  cfg_err_d = 1'b1;
`endif
               end
               default: cfg_err_d = 1'b1;
            endcase
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            state_q[c]  <= StIdle;
            len_q[c]    <= '0;
            cnt_q[c]    <= '0;
            stride_q[c] <= '0;
            base_q[c]   <= '0;
            addr_q[c]   <= '0;
         end
         rr_q      <= '0;
         cfg_err_q <= 1'b0;
         done_q    <= '0;
`ifdef BRAM_AGU_ABORT_EN
         abort_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         stride_q  <= stride_d;
         base_q    <= base_d;
         addr_q    <= addr_d;
         rr_q      <= rr_d;
         cfg_err_q <= cfg_err_d;
         done_q    <= done_d;
`ifdef BRAM_AGU_ABORT_EN
         abort_q   <= abort_d;
`endif
      end
   end

   // Output decode.
   always_comb begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         O_Busy[c] = (state_q[c] == StRun);
      end
   end

   assign O_Req_Valid = req_valid;
   assign O_Req_Ch    = grant;
   assign O_Req_Addr  = addr_q[grant];
   assign O_Cfg_Err   = cfg_err_q;
   assign O_Done      = done_q;
`ifdef BRAM_AGU_ABORT_EN
   assign O_Abort     = abort_q;
`else
   assign O_Abort     = '0;
`endif

endmodule

// File: tb/tb_bram_stride_agu.sv
// Self-checking bench for bram_stride_agu: directed scenarios plus random
// config/Nack traffic against an address-list reference model.
module tb_bram_stride_agu;
   localparam int NCH = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        I_Cfg_Valid = 1'b0;
   logic [1:0]  I_Cfg_Ch = '0;
   logic [2:0]  I_Cfg_Sel = '0;
   logic [12:0] I_Cfg_Data = '0;
   logic        O_Cfg_Err;
   logic        O_Req_Valid;
   logic [1:0]  O_Req_Ch;
   logic [12:0] O_Req_Addr;
   logic        I_Req_Nack = 1'b0;
   logic [3:0]  O_Busy;
   logic [3:0]  O_Done;
   logic [3:0]  O_Abort;

   bram_stride_agu dut (
      .clock       (clock),
      .reset       (reset),
      .I_Cfg_Valid (I_Cfg_Valid),
      .I_Cfg_Ch    (I_Cfg_Ch),
      .I_Cfg_Sel   (I_Cfg_Sel),
      .I_Cfg_Data  (I_Cfg_Data),
      .O_Cfg_Err   (O_Cfg_Err),
      .O_Req_Valid (O_Req_Valid),
      .O_Req_Ch    (O_Req_Ch),
      .O_Req_Addr  (O_Req_Addr),
      .I_Req_Nack  (I_Req_Nack),
      .O_Busy      (O_Busy),
      .O_Done      (O_Done),
      .O_Abort     (O_Abort)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   // Reference model: per-channel list of addresses still to be issued.
   int unsigned m_len [NCH];
   int unsigned m_str [NCH];
   int unsigned m_base[NCH];
   bit          m_run [NCH];
   int unsigned m_q   [NCH][$];
   int          m_rr;
   bit [3:0]    e_done, e_abort;
   bit          e_err;

   int dut_acc;
   int dut_acc_ch[NCH];
   int dut_done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int m_grant();
      for (int i = 0; i < NCH; i++) begin
         if (m_run[(m_rr + i) % NCH]) return (m_rr + i) % NCH;
      end
      return -1;
   endfunction

   function automatic bit m_any_run();
      for (int c = 0; c < NCH; c++) if (m_run[c]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic m_reset();
      for (int c = 0; c < NCH; c++) begin
         m_len[c] = 0; m_str[c] = 0; m_base[c] = 0; m_run[c] = 0;
         m_q[c].delete();
      end
      m_rr = 0; e_done = '0; e_abort = '0; e_err = 1'b0;
   endtask

   // Check current outputs, drive one cycle of inputs, advance model and clock.
   task automatic step(input bit nack, input bit cv = 1'b0, input int ch = 0,
                       input int sel = 0, input int data = 0);
      int       g;
      bit       run_pre [NCH];
      bit       last;
      bit [3:0] be;
      logic [31:0] exp_addr;
      g = m_grant();
      chk("req_valid", 32'(O_Req_Valid), 32'(g >= 0));
      if (g >= 0) begin
         exp_addr = m_q[g][0];
         chk("req_ch", 32'(O_Req_Ch), g);
         chk("req_addr", 32'(O_Req_Addr), exp_addr);
      end
      for (int c = 0; c < NCH; c++) be[c] = m_run[c];
      chk("busy", 32'(O_Busy), 32'(be));
      chk("done", 32'(O_Done), 32'(e_done));
      chk("abort", 32'(O_Abort), 32'(e_abort));
      chk("cfg_err", 32'(O_Cfg_Err), 32'(e_err));
      if (O_Req_Valid === 1'b1 && !nack) begin
         dut_acc++;
         dut_acc_ch[O_Req_Ch]++;
      end
      if (!$isunknown(O_Done)) dut_done += $countones(O_Done);

      I_Req_Nack  = nack;
      I_Cfg_Valid = cv;
      I_Cfg_Ch    = ch[1:0];
      I_Cfg_Sel   = sel[2:0];
      I_Cfg_Data  = data[12:0];

      e_done = '0; e_abort = '0; e_err = 1'b0; last = 1'b0;
      for (int c = 0; c < NCH; c++) run_pre[c] = m_run[c];
      if (g >= 0 && !nack) begin
         void'(m_q[g].pop_front());
         m_rr = (g + 1) % NCH;
         if (m_q[g].size() == 0) begin
            m_run[g] = 1'b0; e_done[g] = 1'b1; last = 1'b1;
         end
      end
      if (cv) begin
         if (sel <= 3) begin
            if (run_pre[ch]) e_err = 1'b1;
            else if (sel == 0) m_len[ch] = data & 32'h1FFF;
            else if (sel == 1) m_str[ch] = data & 32'h1FFF;
            else if (sel == 2) m_base[ch] = data & 32'h1FFF;
            else if (m_len[ch] == 0) e_done[ch] = 1'b1;
            else begin
               m_q[ch].delete();
               for (int unsigned k = 0; k < m_len[ch]; k++)
                  m_q[ch].push_back((m_base[ch] + k * m_str[ch]) % 8192);
               m_run[ch] = 1'b1;
            end
         end else if (sel == 4) begin
`ifdef BRAM_AGU_ABORT_EN
            if (run_pre[ch] && !(last && g == ch)) begin
               m_run[ch] = 1'b0; m_q[ch].delete(); e_abort[ch] = 1'b1;
            end
`else
            e_err = 1'b1;
`endif
         end else begin
            e_err = 1'b1;
         end
      end

      @(posedge clock);
      #1;
      I_Cfg_Valid = 1'b0;
      I_Req_Nack  = 1'b0;
   endtask

   // Run until the model has no active channel (bounded), then one more cycle
   // to observe the trailing Done pulses.
   task automatic drain(input int nack_pct);
      int n;
      n = 0;
      while (m_any_run() && n < 400) begin
         step($urandom_range(0, 99) < nack_pct);
         n++;
      end
      step(1'b0);
      chk("drained_busy", 32'(O_Busy), 32'h0);
   endtask

   task automatic clr_counts();
      dut_acc = 0; dut_done = 0;
      for (int c = 0; c < NCH; c++) dut_acc_ch[c] = 0;
   endtask

   initial begin
      int sel;
      int data;
      m_reset();
      clr_counts();
      #12;
      chk("reset_valid", 32'(O_Req_Valid), 32'h0);
      chk("reset_busy", 32'(O_Busy), 32'h0);
      @(posedge clock); #1;
      reset = 1'b1;
      step(1'b0);

      // Ch0: 0x100, 0x104, 0x108.
      step(0, 1, 0, 0, 3);
      step(0, 1, 0, 1, 4);
      step(0, 1, 0, 2, 'h100);
      step(0, 1, 0, 3, 0);
      drain(0);

      // Ch1: wrap at 13 bits.
      step(0, 1, 1, 0, 4);
      step(0, 1, 1, 1, 1);
      step(0, 1, 1, 2, 'h1FFE);
      step(0, 1, 1, 3, 0);
      drain(0);

      // All four channels, Len=2, distinct strides.
      for (int c = 0; c < NCH; c++) begin
         step(0, 1, c, 0, 2);
         step(0, 1, c, 1, c + 1);
         step(0, 1, c, 2, c * 'h40);
      end
      clr_counts();
      for (int c = 0; c < NCH; c++) step(0, 1, c, 3, 0);
      drain(0);
      chk("all_ch_accepts", dut_acc, 8);
      chk("all_ch_dones", dut_done, 4);

      // Ch2 stalled by Nack for 5 cycles mid-transfer.
      step(0, 1, 2, 0, 6);
      step(0, 1, 2, 1, 3);
      step(0, 1, 2, 2, 'h20);
      step(0, 1, 2, 3, 0);
      step(0);
      step(0);
      repeat (5) step(1);
      drain(0);

      // LENGTH write to running Ch0, then START with Len=0 on Ch1.
      step(0, 1, 0, 0, 4);
      step(0, 1, 0, 3, 0);
      step(0);
      step(0, 1, 0, 0, 9);
      drain(0);
      clr_counts();
      step(0, 1, 1, 0, 0);
      step(0, 1, 1, 3, 0);
      step(0);
      chk("len0_accepts", dut_acc, 0);
      chk("len0_dones", dut_done, 1);

      // Sel=4 on Ch3 after 2 of 5 words; a reserved-Sel error without the feature.
      step(0, 1, 3, 0, 5);
      step(0, 1, 3, 1, 2);
      step(0, 1, 3, 2, 'h80);
      clr_counts();
      step(0, 1, 3, 3, 0);
      step(0);
      step(0);
      step(1, 1, 3, 4, 0);
      step(0);
      drain(0);
`ifdef BRAM_AGU_ABORT_EN
      chk("abort_accepts", dut_acc_ch[3], 2);
      chk("abort_no_done", dut_done, 0);
`else
      chk("noabort_accepts", dut_acc_ch[3], 5);
`endif
      step(0, 1, 5, 7, 0);
      step(0, 1, 2, 6, 0);
      step(0);

      // Reset mid-transfer on Ch3.
      step(0, 1, 3, 3, 0);
      step(0);
      step(0);
      #2 reset = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(O_Req_Valid), 32'h0);
      chk("rst_mid_busy", 32'(O_Busy), 32'h0);
      chk("rst_mid_done", 32'(O_Done), 32'h0);
      @(posedge clock); #1;
      reset = 1'b1;
      m_reset();
      clr_counts();
      repeat (3) step(0);
      chk("rst_no_done", dut_done, 0);

      // Random config and Nack traffic.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            sel = ($urandom_range(0, 2) == 0) ? 3 : $urandom_range(0, 7);
            data = (sel == 0) ? $urandom_range(0, 6) : $urandom_range(0, 8191);
            step($urandom_range(0, 3) == 0, 1, $urandom_range(0, 3), sel, data);
         end else begin
            step($urandom_range(0, 3) == 0);
         end
      end
      drain(25);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
